code_patch_wb_regs: RTL and testbench

- Wishbone B4 pipelined slave register block that owns the code-patch configuration and control registers.
- It drives the cfg_pat_*/ctl_pat_* inputs of the code-patch bus wrapper. Software writes pattern registers into a shadow bank.
- A COMMIT request copies the shadow bank into the live outputs atomically, deferred until the patched bus is idle. This means a patch never changes mid-transaction.

---
 rtl/code_patch_regs_pkg.sv | 19 +
 rtl/code_patch_wb_slave_if.sv | 42 ++++
 rtl/code_patch_wb_regs.sv | 170 +++++++++++++++++
 tb/tb_code_patch_wb_regs.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/code_patch_regs_pkg.sv
// Shared register map, CTRL bit layout and commit-FSM state type for the
// code-patch configuration register block.
package code_patch_regs_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_PEN      = 1;
  localparam int unsigned REG_NOPG     = 2;
  localparam int unsigned REG_COMMIT   = 3;
  localparam int unsigned REG_PAT_BASE = 4;

  localparam int unsigned CTRL_PAT_GEN_BIT      = 0;
  localparam int unsigned CTRL_ADDR_OR_DATA_BIT = 1;

  typedef enum logic {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/code_patch_wb_slave_if.sv
// Wishbone B4 pipelined slave front end: accepts a request every cycle, flags
// unmapped addresses and registers the single-cycle ack/err and read data.
module code_patch_wb_slave_if #(
  parameter int unsigned REG_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_WORDS      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cyc,
  input  logic                      stb,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      wr_en,
  output logic                      ack,
  output logic                      err,
  output logic [DATA_WIDTH-1:0]     dat
);

  logic accept;
  logic mapped;

  assign accept = cyc & stb;
  assign mapped = 32'(adr) < 32'(NUM_WORDS);
  assign wr_en  = accept & we & mapped;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack <= 1'b0;
      err <= 1'b0;
      dat <= '0;
    end else begin
      ack <= accept & mapped;
      err <= accept & ~mapped;
      dat <= (accept & mapped & ~we) ? rd_data : '0;
    end
  end

endmodule

// File: rtl/code_patch_wb_regs.sv
// Code-patch configuration registers: a software-visible shadow bank and a live
// bank that is refreshed atomically by COMMIT once the patched bus is idle.
module code_patch_wb_regs
  import code_patch_regs_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned PATCH_ADDR_WIDTH = 16,
  parameter int unsigned PATCH_DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS         = 2,
  parameter int unsigned SEL_WIDTH        = DATA_WIDTH / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [DATA_WIDTH-1:0]                     wb_dat_i,
  input  logic [REG_ADDR_WIDTH-1:0]                 wb_adr_i,
  input  logic                                      wb_cyc_i,
  input  logic                                      wb_stb_i,
  input  logic                                      wb_we_i,
  input  logic [SEL_WIDTH-1:0]                      wb_sel_i,
  output logic [DATA_WIDTH-1:0]                     wb_dat_o,
  output logic                                      wb_ack_o,
  output logic                                      wb_err_o,
  output logic                                      wb_stall_o,
  input  logic                                      patch_bus_busy_i,
  output logic                                      cfg_pat_gen_o,
  output logic                                      cfg_addr_or_data_o,
  output logic [NUM_REGS-1:0][PATCH_ADDR_WIDTH-1:0] ctl_pat_addr_o,
  output logic [NUM_REGS-1:0][PATCH_DATA_WIDTH-1:0] ctl_pat_data_o,
  output logic [NUM_REGS-1:0]                       ctl_pat_pen_o,
  output logic [NUM_REGS-1:0]                       ctl_pat_nopg_o
);

  localparam int unsigned NUM_WORDS = REG_PAT_BASE + 2 * NUM_REGS;

  if (PATCH_ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
    $error("PATCH_ADDR_WIDTH must not exceed DATA_WIDTH");
  end
  if (PATCH_DATA_WIDTH > DATA_WIDTH) begin : g_bad_data_width
    $error("PATCH_DATA_WIDTH must not exceed DATA_WIDTH");
  end
  if (NUM_REGS < 1 || NUM_REGS > DATA_WIDTH) begin : g_bad_num_regs
    $error("NUM_REGS must be in 1..DATA_WIDTH");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end

  logic [1:0]                                ctrl_q;
  logic [NUM_REGS-1:0]                       pen_q;
  logic [NUM_REGS-1:0]                       nopg_q;
  logic [NUM_REGS-1:0][PATCH_ADDR_WIDTH-1:0] pat_addr_q;
  logic [NUM_REGS-1:0][PATCH_DATA_WIDTH-1:0] pat_data_q;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  commit_req;
  logic                  do_copy;
  commit_state_e         state_q, state_d;

  code_patch_wb_slave_if #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_WORDS      (NUM_WORDS)
  ) u_slave_if (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cyc     (wb_cyc_i),
    .stb     (wb_stb_i),
    .we      (wb_we_i),
    .adr     (wb_adr_i),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .ack     (wb_ack_o),
    .err     (wb_err_o),
    .dat     (wb_dat_o)
  );

  assign wb_stall_o = 1'b0;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    if (wb_adr_i == REG_ADDR_WIDTH'(REG_CTRL))   rd_data[1:0]          = ctrl_q;
    if (wb_adr_i == REG_ADDR_WIDTH'(REG_PEN))    rd_data[NUM_REGS-1:0] = pen_q;
    if (wb_adr_i == REG_ADDR_WIDTH'(REG_NOPG))   rd_data[NUM_REGS-1:0] = nopg_q;
    if (wb_adr_i == REG_ADDR_WIDTH'(REG_COMMIT)) rd_data[0] = (state_q == COMMIT_PENDING);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (wb_adr_i == REG_ADDR_WIDTH'(REG_PAT_BASE + 2 * i))
        rd_data[PATCH_ADDR_WIDTH-1:0] = pat_addr_q[i];
      if (wb_adr_i == REG_ADDR_WIDTH'(REG_PAT_BASE + 2 * i + 1))
        rd_data[PATCH_DATA_WIDTH-1:0] = pat_data_q[i];
    end
  end

  // The read mux already holds the addressed register, so merging it with the
  // write data under the byte selects yields the post-write word.
  always_comb begin
    wr_word = rd_data;
    for (int b = 0; b < int'(SEL_WIDTH); b++) begin
      if (wb_sel_i[b]) wr_word[b*8 +: 8] = wb_dat_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      pen_q      <= '0;
      nopg_q     <= '0;
      pat_addr_q <= '0;
      pat_data_q <= '0;
    end else if (wr_en) begin
      if (wb_adr_i == REG_ADDR_WIDTH'(REG_CTRL)) ctrl_q <= wr_word[1:0];
      if (wb_adr_i == REG_ADDR_WIDTH'(REG_PEN))  pen_q  <= wr_word[NUM_REGS-1:0];
      if (wb_adr_i == REG_ADDR_WIDTH'(REG_NOPG)) nopg_q <= wr_word[NUM_REGS-1:0];
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wb_adr_i == REG_ADDR_WIDTH'(REG_PAT_BASE + 2 * i))
          pat_addr_q[i] <= wr_word[PATCH_ADDR_WIDTH-1:0];
        if (wb_adr_i == REG_ADDR_WIDTH'(REG_PAT_BASE + 2 * i + 1))
          pat_data_q[i] <= wr_word[PATCH_DATA_WIDTH-1:0];
      end
    end
  end

  assign commit_req = wr_en && (wb_adr_i == REG_ADDR_WIDTH'(REG_COMMIT))
                      && wb_sel_i[0] && wb_dat_i[0];

  always_comb begin
    state_d = state_q;
    do_copy = 1'b0;
    unique case (state_q)
      COMMIT_IDLE: begin
        if (commit_req) state_d = COMMIT_PENDING;
      end
      COMMIT_PENDING: begin
        if (!patch_bus_busy_i) begin
          do_copy = 1'b1;
          state_d = COMMIT_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= COMMIT_IDLE;
    else         state_q <= state_d;
  end

  // The copy samples the shadow bank before any write landing on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_pat_gen_o      <= 1'b0;
      cfg_addr_or_data_o <= 1'b0;
      ctl_pat_pen_o      <= '0;
      ctl_pat_nopg_o     <= '0;
      ctl_pat_addr_o     <= '0;
      ctl_pat_data_o     <= '0;
    end else if (do_copy) begin
      cfg_pat_gen_o      <= ctrl_q[CTRL_PAT_GEN_BIT];
      cfg_addr_or_data_o <= ctrl_q[CTRL_ADDR_OR_DATA_BIT];
      ctl_pat_pen_o      <= pen_q;
      ctl_pat_nopg_o     <= nopg_q;
      ctl_pat_addr_o     <= pat_addr_q;
      ctl_pat_data_o     <= pat_data_q;
    end
  end

endmodule

// File: tb/tb_code_patch_wb_regs.sv
// Self-checking bench for code_patch_wb_regs: table-driven bus vectors with a
// response scoreboard, plus directed commit, race and reset sequences.
module tb_code_patch_wb_regs;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [15:0]       wb_dat_i = '0;
  logic [7:0]        wb_adr_i = '0;
  logic              wb_cyc_i = 1'b0;
  logic              wb_stb_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [1:0]        wb_sel_i = '0;
  logic [15:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              wb_err_o;
  logic              wb_stall_o;
  logic              patch_bus_busy_i = 1'b0;
  logic              cfg_pat_gen_o;
  logic              cfg_addr_or_data_o;
  logic [1:0][15:0]  ctl_pat_addr_o;
  logic [1:0][15:0]  ctl_pat_data_o;
  logic [1:0]        ctl_pat_pen_o;
  logic [1:0]        ctl_pat_nopg_o;

  always #5 clk_i = ~clk_i;

  code_patch_wb_regs dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .wb_dat_i           (wb_dat_i),
    .wb_adr_i           (wb_adr_i),
    .wb_cyc_i           (wb_cyc_i),
    .wb_stb_i           (wb_stb_i),
    .wb_we_i            (wb_we_i),
    .wb_sel_i           (wb_sel_i),
    .wb_dat_o           (wb_dat_o),
    .wb_ack_o           (wb_ack_o),
    .wb_err_o           (wb_err_o),
    .wb_stall_o         (wb_stall_o),
    .patch_bus_busy_i   (patch_bus_busy_i),
    .cfg_pat_gen_o      (cfg_pat_gen_o),
    .cfg_addr_or_data_o (cfg_addr_or_data_o),
    .ctl_pat_addr_o     (ctl_pat_addr_o),
    .ctl_pat_data_o     (ctl_pat_data_o),
    .ctl_pat_pen_o      (ctl_pat_pen_o),
    .ctl_pat_nopg_o     (ctl_pat_nopg_o)
  );

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        exp_err;
    logic [15:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic        exp_err;
    logic [15:0] exp_dat;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] adr, input logic [15:0] dat,
                       input logic [1:0] sel, input logic exp_err, input logic [15:0] exp_dat);
    resp_t r;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    r.we = we; r.adr = adr; r.exp_err = exp_err; r.exp_dat = exp_dat;
    sb_q.push_back(r);
  endtask

  task automatic req(input logic we, input logic [7:0] adr, input logic [15:0] dat,
                     input logic [1:0] sel, input logic exp_err, input logic [15:0] exp_dat);
    @(negedge clk_i);
    drive(we, adr, dat, sel, exp_err, exp_dat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
    end
  endtask

  task automatic check_live(input string tag, input logic gen, input logic aod,
                            input logic [1:0] pen, input logic [1:0] nopg,
                            input logic [31:0] addrs, input logic [31:0] datas);
    check({tag, "_ctl"}, 64'({cfg_pat_gen_o, cfg_addr_or_data_o, ctl_pat_pen_o, ctl_pat_nopg_o}),
          64'({gen, aod, pen, nopg}));
    check({tag, "_addr"}, 64'(ctl_pat_addr_o), 64'(addrs));
    check({tag, "_data"}, 64'(ctl_pat_data_o), 64'(datas));
  endtask

  // Every accepted request must be answered on the very next edge.
  always @(posedge clk_i) begin
    resp_t e;
    mon_acc = wb_cyc_i & wb_stb_i & rst_ni;
    #1;
    if (mon_acc) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("resp_kind_%02h", e.adr), 64'({wb_ack_o, wb_err_o}),
              64'(e.exp_err ? 2'b01 : 2'b10));
        check("stall", 64'(wb_stall_o), 64'(0));
        if (!e.we || e.exp_err)
          check($sformatf("rdata_%02h", e.adr), 64'(wb_dat_o), 64'(e.exp_dat));
      end
    end else if (wb_ack_o || wb_err_o) begin
      check("spurious_resp", 64'({wb_ack_o, wb_err_o}), 64'(0));
    end
  end

  initial begin
    //             we    adr    dat       sel    err   exp_dat
    vecs.push_back('{1'b0, 8'h06, 16'h0000, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 8'h06, 16'h1234, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h06, 16'h0000, 2'b11, 1'b0, 16'h1234});
    vecs.push_back('{1'b1, 8'h06, 16'hBEEF, 2'b01, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h06, 16'h0000, 2'b11, 1'b0, 16'h12EF});
    vecs.push_back('{1'b1, 8'h00, 16'hFFFF, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h00, 16'h0000, 2'b11, 1'b0, 16'h0003});
    vecs.push_back('{1'b1, 8'h01, 16'hFFFE, 2'b01, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 8'h02, 16'h0001, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h02, 16'h0000, 2'b11, 1'b0, 16'h0001});
    vecs.push_back('{1'b1, 8'h04, 16'hA5A5, 2'b10, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 8'h05, 16'h5A5A, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b1, 8'h07, 16'hC3C3, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h07, 16'h0000, 2'b11, 1'b0, 16'hC3C3});
    vecs.push_back('{1'b1, 8'h03, 16'h0001, 2'b10, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0000});
    vecs.push_back('{1'b0, 8'h08, 16'h0000, 2'b11, 1'b1, 16'h0000});
    vecs.push_back('{1'b1, 8'h08, 16'hFFFF, 2'b11, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'hFF, 16'h0000, 2'b11, 1'b1, 16'h0000});
    vecs.push_back('{1'b0, 8'h04, 16'h0000, 2'b11, 1'b0, 16'hA500});
    vecs.push_back('{1'b0, 8'h05, 16'h0000, 2'b11, 1'b0, 16'h5A5A});
    vecs.push_back('{1'b0, 8'h01, 16'h0000, 2'b11, 1'b0, 16'h0002});

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("reset_resp", 64'({wb_ack_o, wb_err_o, wb_dat_o}), 64'(0));
    check_live("reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);

    foreach (vecs[i])
      req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_err, vecs[i].exp_dat);
    idle(2);
    check_live("no_commit", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);

    // Commit deferred while the patched bus is busy.
    patch_bus_busy_i = 1'b1;
    req(1'b1, 8'h03, 16'h0001, 2'b01, 1'b0, 16'h0000);
    req(1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0001);
    repeat (4) begin
      idle(1);
      @(posedge clk_i); #1;
      check_live("busy_hold", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    end
    @(negedge clk_i);
    patch_bus_busy_i = 1'b0;
    @(posedge clk_i); #1;
    check_live("commit", 1'b1, 1'b1, 2'b10, 2'b01, {16'h12EF, 16'hA500}, {16'hC3C3, 16'h5A5A});
    req(1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0000);

    // Shadow write on the same edge as the copy: live takes the pre-write value.
    patch_bus_busy_i = 1'b1;
    req(1'b1, 8'h01, 16'h0001, 2'b01, 1'b0, 16'h0000);
    req(1'b1, 8'h03, 16'h0001, 2'b01, 1'b0, 16'h0000);
    @(negedge clk_i);
    patch_bus_busy_i = 1'b0;
    drive(1'b1, 8'h01, 16'h0002, 2'b01, 1'b0, 16'h0000);
    @(posedge clk_i); #1;
    check("race_live_pen", 64'(ctl_pat_pen_o), 64'(2'b01));
    req(1'b0, 8'h01, 16'h0000, 2'b11, 1'b0, 16'h0002);
    req(1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0000);
    idle(2);

    // Reset while a commit is pending discards it.
    patch_bus_busy_i = 1'b1;
    req(1'b1, 8'h03, 16'h0001, 2'b01, 1'b0, 16'h0000);
    req(1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0001);
    idle(1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_resp", 64'({wb_ack_o, wb_err_o, wb_dat_o}), 64'(0));
    check_live("rst_async", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    req(1'b0, 8'h03, 16'h0000, 2'b11, 1'b0, 16'h0000);
    req(1'b0, 8'h06, 16'h0000, 2'b11, 1'b0, 16'h0000);
    req(1'b0, 8'h00, 16'h0000, 2'b11, 1'b0, 16'h0000);
    idle(1);
    patch_bus_busy_i = 1'b0;
    idle(3);
    check_live("post_reset", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
